// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: op codes, data width, FSM states.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; zero is only meaningful for sub (a == b), cleared otherwise.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o,
    output logic            zero_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        res_o  = a_i;
        zero_o = 1'b0;
        case (op_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB: begin
                res_o  = a_i - b_i;
                zero_o = (a_i == b_i);
            end
            ALU_SLL:  res_o = a_i << shamt;
            ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_SRL:  res_o = a_i >> shamt;
            ALU_SRA:  res_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   res_o = a_i | b_i;
            ALU_AND:  res_o = a_i & b_i;
            default:  res_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; one operation in flight,
// operands and result registered, round-robin or fixed-priority arbitration.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_0,
    input  logic            req_valid_1,
    output logic            req_ready_0,
    output logic            req_ready_1,
    input  logic [3:0]      req_op_0,
    input  logic [3:0]      req_op_1,
    input  logic [XLEN-1:0] req_a_0,
    input  logic [XLEN-1:0] req_a_1,
    input  logic [XLEN-1:0] req_b_0,
    input  logic [XLEN-1:0] req_b_1,
    output logic            resp_valid_0,
    output logic            resp_valid_1,
    input  logic            resp_ready_0,
    input  logic            resp_ready_1,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_zero,
    output logic            busy
);

    arb_state_e      state_q;
    logic            last_gnt_q;
    logic            gnt_id_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [1:0]      resp_valid_q;

    logic            gnt_d;
    logic            any_valid;
    logic            resp_take;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;

    assign any_valid = req_valid_0 | req_valid_1;

    // On a tie the port not granted last wins, unless port 0 is fixed-priority.
    always_comb begin
        gnt_d = req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            gnt_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_q;
        end
    end

    // Gated with rst_n so no request is accepted while reset is held.
    assign req_ready_0 = rst_n && (state_q == StIdle) && req_valid_0 && !gnt_d;
    assign req_ready_1 = rst_n && (state_q == StIdle) && req_valid_1 && gnt_d;

    assign resp_take = gnt_id_q ? resp_ready_1 : resp_ready_0;

    alu u_alu (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .res_o  (alu_res),
        .zero_o (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_gnt_q   <= 1'b1;
            gnt_id_q     <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            resp_valid_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        op_q       <= gnt_d ? req_op_1 : req_op_0;
                        a_q        <= gnt_d ? req_a_1 : req_a_0;
                        b_q        <= gnt_d ? req_b_1 : req_b_0;
                        gnt_id_q   <= gnt_d;
                        last_gnt_q <= gnt_d;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    res_q                  <= alu_res;
                    zero_q                 <= alu_zero;
                    resp_valid_q[gnt_id_q] <= 1'b1;
                    state_q                <= StResp;
                end
                StResp: begin
                    if (resp_take) begin
                        resp_valid_q <= 2'b00;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_valid_0 = resp_valid_q[0];
    assign resp_valid_1 = resp_valid_q[1];
    assign resp_data    = res_q;
    assign resp_zero    = zero_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: drives at the falling edge, samples 1 ns later.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [1:0]  rsp_v;
    logic [1:0]  rsp_r;
    logic [3:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] resp_data;
    logic        resp_zero;
    logic        busy;

    int n_vec;
    int n_err;

    alu_arbiter #(
        .FIXED_PRIO (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_0  (vld[0]),
        .req_valid_1  (vld[1]),
        .req_ready_0  (rdy[0]),
        .req_ready_1  (rdy[1]),
        .req_op_0     (op[0]),
        .req_op_1     (op[1]),
        .req_a_0      (a[0]),
        .req_a_1      (a[1]),
        .req_b_0      (b[0]),
        .req_b_1      (b[1]),
        .resp_valid_0 (rsp_v[0]),
        .resp_valid_1 (rsp_v[1]),
        .resp_ready_0 (rsp_r[0]),
        .resp_ready_1 (rsp_r[1]),
        .resp_data    (resp_data),
        .resp_zero    (resp_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 12) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // One full transaction on port p with its response consumed immediately.
    task automatic run_op(input int p, input logic [3:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ed, input logic ez);
        logic [1:0] mine;
        mine = (p == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        vld = mine; op[p] = o; a[p] = av; b[p] = bv; rsp_r = mine;
        #1;
        check("op_ready", {30'd0, rdy}, {30'd0, mine});
        @(negedge clk);
        vld = 2'b00;
        #1;
        check("op_exec_busy", {31'd0, busy}, 32'd1);
        check("op_exec_novalid", {30'd0, rsp_v}, 32'd0);
        @(negedge clk);
        #1;
        check("op_resp_valid", {30'd0, rsp_v}, {30'd0, mine});
        check("op_data", resp_data, ed);
        check("op_zero", {31'd0, resp_zero}, {31'd0, ez});
        @(negedge clk);
        #1;
        check("op_done", {30'd0, rsp_v, busy}, 32'd0);
        rsp_r = 2'b00;
    endtask

    initial begin
        int grants;
        int k;
        logic [1:0] gseq [4];
        logic [1:0] gexp [4];
        n_vec = 0;
        n_err = 0;
        vld = 2'b01; rsp_r = 2'b00;
        for (int i = 0; i < 2; i++) begin
            op[i] = '0; a[i] = '0; b[i] = '0;
        end
        rst_n = 1'b0;
        #23;
        check("rst_ready", {30'd0, rdy}, 32'd0);
        check("rst_outputs", {29'd0, rsp_v, busy}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_zero", {31'd0, resp_zero}, 32'd0);
        vld = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight after reset: port 0 first, loser holds valid and wins next.
        @(negedge clk);
        vld = 2'b11; rsp_r = 2'b11;
        op[0] = 4'b0001; a[0] = 32'd1;          b[0] = 32'd33;
        op[1] = 4'b1101; a[1] = 32'h8000_0000;  b[1] = 32'd4;
        #1;
        check("tie_rdy0", {30'd0, rdy}, 32'd1);
        @(negedge clk);
        vld[0] = 1'b0;
        #1;
        check("tie_exec_noready", {30'd0, rdy}, 32'd0);
        @(negedge clk);
        #1;
        check("tie_resp0_valid", {30'd0, rsp_v}, 32'd1);
        check("tie_resp0_data", resp_data, 32'd2);
        @(negedge clk);
        #1;
        check("tie_rdy1", {30'd0, rdy}, 32'd2);
        @(negedge clk);
        vld[1] = 1'b0;
        #1;
        @(negedge clk);
        #1;
        check("tie_resp1_valid", {30'd0, rsp_v}, 32'd2);
        check("tie_resp1_data", resp_data, 32'hF800_0000);
        check("tie_resp1_zero", {31'd0, resp_zero}, 32'd0);
        wait_idle();

        // Continuous ties: last grant was port 1, so 0,1,0,1.
        gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
        grants = 0;
        k = 0;
        @(negedge clk);
        vld = 2'b11; rsp_r = 2'b11;
        op[0] = 4'b0000; op[1] = 4'b0000;
        while (grants < 4 && k < 40) begin
            #1;
            if (rdy != 2'b00) begin
                gseq[grants] = rdy;
                grants++;
            end
            k++;
            if (grants < 4) @(negedge clk);
        end
        check("rr_grant_count", grants, 32'd4);
        for (int i = 0; i < grants; i++) begin
            check("rr_grant_seq", {30'd0, gseq[i]}, {30'd0, gexp[i]});
        end
        @(negedge clk);
        vld = 2'b00;
        #1;
        wait_idle();
        rsp_r = 2'b00;

        run_op(0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
        run_op(1, 4'b1000, 32'h1234, 32'h1234, 32'd0, 1'b1);
        run_op(1, 4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        run_op(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);

        // Backpressure on port 0 while port 1 keeps requesting.
        @(negedge clk);
        vld = 2'b01; op[0] = 4'b0000; a[0] = 32'd3; b[0] = 32'd4; rsp_r = 2'b00;
        #1;
        check("bp_rdy0", {30'd0, rdy}, 32'd1);
        @(negedge clk);
        vld = 2'b10; op[1] = 4'b0000; a[1] = 32'd1; b[1] = 32'd1;
        #1;
        @(negedge clk);
        #1;
        check("bp_first_valid", {30'd0, rsp_v}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", {30'd0, rsp_v}, 32'd1);
            check("bp_hold_data", resp_data, 32'd7);
            check("bp_hold_busy_rdy", {29'd0, busy, rdy}, 32'd4);
        end
        @(negedge clk);
        rsp_r = 2'b01;
        #1;
        check("bp_release_valid", {30'd0, rsp_v}, 32'd1);
        @(negedge clk);
        rsp_r = 2'b10;
        #1;
        check("bp_idle_next", {29'd0, busy, rsp_v}, 32'd0);
        check("bp_rdy1_after", {30'd0, rdy}, 32'd2);
        @(negedge clk);
        vld = 2'b00;
        #1;
        @(negedge clk);
        #1;
        check("bp_resp1_valid", {30'd0, rsp_v}, 32'd2);
        check("bp_resp1_data", resp_data, 32'd2);
        @(negedge clk);
        #1;
        wait_idle();
        rsp_r = 2'b00;

        run_op(0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
        run_op(0, 4'b0011, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Reset pulse while the operation sits in EXEC.
        @(negedge clk);
        vld = 2'b01; op[0] = 4'b0000; a[0] = 32'd1; b[0] = 32'd2; rsp_r = 2'b01;
        #1;
        @(negedge clk);
        vld = 2'b00;
        #1;
        check("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {29'd0, busy, rsp_v}, 32'd0);
        check("mid_rst_data", resp_data, 32'd0);
        check("mid_rst_zero", {31'd0, resp_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", {29'd0, busy, rsp_v}, 32'd0);
        end
        @(negedge clk);
        vld = 2'b11;
        #1;
        check("post_rst_tie", {30'd0, rdy}, 32'd1);
        @(negedge clk);
        vld = 2'b00; rsp_r = 2'b11;
        #1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
